// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: the canonical NOP,
// the default reset vector and the fetch FSM state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries between the
// instruction memory and the IF/ID register. DEPTH must be a power of two.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DW-1:0]          head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited in-order
// requests to instruction memory and buffers responses for the IF/ID stage.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [31:0]      if_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = WIDTH + 32;

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;

    logic [WIDTH-1:0] pcq_q [DEPTH];
    logic [WIDTH-1:0] pcq_d [DEPTH];
    logic [AW-1:0]    pcq_wr_q, pcq_wr_d;
    logic [AW-1:0]    pcq_rd_q, pcq_rd_d;

    logic [WIDTH-1:0] redirect_target;
    logic             unused_redirect_lsbs;
    logic [CW:0]      credits;
    logic             gnt_fire;
    logic             rsp_live;
    logic             rsp_keep;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [DW-1:0]    fifo_head;

    assign redirect_target      = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits count every slot already promised: requests in flight plus
    // entries waiting in the buffer, so each response always finds room.
    assign credits   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req  = !rst && (state_q == FETCH) && !redirect
                       && (credits < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;
    assign gnt_fire  = imem_req && imem_gnt;

    assign rsp_live  = imem_rvalid && (outstanding_q != '0);
    assign rsp_keep  = rsp_live && (state_q == FETCH) && !redirect;

    assign if_valid  = !fifo_empty;
    assign fifo_pop  = if_valid && !stall && !redirect;
    assign if_pc     = if_valid ? fifo_head[DW-1:32] : '0;
    assign if_instr  = if_valid ? fifo_head[31:0] : NOP_INSTR;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ({pcq_q[pcq_rd_q], imem_rdata}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        pcq_d         = pcq_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    // Everything still in flight belongs to the old path.
                    pc_d          = redirect_target;
                    drop_d        = outstanding_q + CW'(gnt_fire) - CW'(rsp_live);
                    outstanding_d = '0;
                    pcq_wr_d      = '0;
                    pcq_rd_d      = '0;
                    state_d       = (drop_d != '0) ? FLUSH : FETCH;
                end else begin
                    if (gnt_fire) begin
                        pc_d            = pc_q + WIDTH'(4);
                        pcq_d[pcq_wr_q] = pc_q;
                        pcq_wr_d        = pcq_wr_q + AW'(1);
                    end
                    if (rsp_keep) begin
                        pcq_rd_d = pcq_rd_q + AW'(1);
                    end
                    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_keep);
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_rvalid && (drop_q != '0)) begin
                    drop_d = drop_q - CW'(1);
                    if (drop_q == CW'(1)) begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        pcq_q <= pcq_d;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed cycle table for the fetch unit plus a randomized latency/stall
// stream checked against a simple in-order memory and PC sequence model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam int          NVEC = 27;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInstr;
    } vec_t;

    vec_t vecs [NVEC];

    if_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0040_0000),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, logic g,
                                logic rv, logic [31:0] rd, logic er,
                                logic [31:0] ea, logic ev, logic [31:0] ep,
                                logic [31:0] ei);
        vec_t v;
        v.stall = s;  v.redirect = r; v.rpc = rpc; v.gnt = g;
        v.rvalid = rv; v.rdata = rd;  v.eReq = er; v.eAddr = ea;
        v.eValid = ev; v.ePc = ep;    v.eInstr = ei;
        return v;
    endfunction

    task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rvalid;
        imem_rdata  = v.rdata;
    endtask

    task automatic checkOutput(vec_t v, int step);
        check32($sformatf("step%0d imem_req", step), {31'b0, imem_req}, {31'b0, v.eReq});
        check32($sformatf("step%0d imem_addr", step), imem_addr, v.eAddr);
        check32($sformatf("step%0d if_valid", step), {31'b0, if_valid}, {31'b0, v.eValid});
        check32($sformatf("step%0d if_pc", step), if_pc, v.ePc);
        check32($sformatf("step%0d if_instr", step), if_instr, v.eInstr);
    endtask

    initial begin
        logic [31:0] mq [$];
        int          due [$];
        logic [31:0] expPc;
        logic [31:0] expReqAddr;
        logic [31:0] tmpAddr;
        int          tmpDue;
        int          buffered;
        int          consumed;
        int          cyc;
        int          lastDue;
        int          d;

        // stall, redir, rpc, gnt, rvalid, rdata | req, addr, valid, pc, instr
        vecs[0]  = mk(0,0,0,1,0,0,               1,32'h0040_0000,0,0,NOP);
        vecs[1]  = mk(0,0,0,1,1,32'h1000_0000,   1,32'h0040_0004,0,0,NOP);
        vecs[2]  = mk(0,0,0,1,1,32'h1000_0001,   1,32'h0040_0008,1,32'h0040_0000,32'h1000_0000);
        vecs[3]  = mk(0,0,0,1,1,32'h1000_0002,   1,32'h0040_000C,1,32'h0040_0004,32'h1000_0001);
        vecs[4]  = mk(1,0,0,1,1,32'h1000_0003,   1,32'h0040_0010,1,32'h0040_0008,32'h1000_0002);
        vecs[5]  = mk(1,0,0,1,1,32'h1000_0004,   1,32'h0040_0014,1,32'h0040_0008,32'h1000_0002);
        vecs[6]  = mk(1,0,0,1,1,32'h1000_0005,   0,32'h0040_0018,1,32'h0040_0008,32'h1000_0002);
        vecs[7]  = mk(1,0,0,1,0,0,               0,32'h0040_0018,1,32'h0040_0008,32'h1000_0002);
        vecs[8]  = mk(0,0,0,1,0,0,               0,32'h0040_0018,1,32'h0040_0008,32'h1000_0002);
        vecs[9]  = mk(0,0,0,1,0,0,               1,32'h0040_0018,1,32'h0040_000C,32'h1000_0003);
        vecs[10] = mk(0,0,0,0,1,32'h1000_0006,   1,32'h0040_001C,1,32'h0040_0010,32'h1000_0004);
        vecs[11] = mk(0,0,0,0,0,0,               1,32'h0040_001C,1,32'h0040_0014,32'h1000_0005);
        vecs[12] = mk(1,0,0,1,0,0,               1,32'h0040_001C,1,32'h0040_0018,32'h1000_0006);
        vecs[13] = mk(1,0,0,1,0,0,               1,32'h0040_0020,1,32'h0040_0018,32'h1000_0006);
        vecs[14] = mk(1,1,32'h0040_0103,1,0,0,   0,32'h0040_0024,1,32'h0040_0018,32'h1000_0006);
        vecs[15] = mk(0,0,0,1,1,32'hDEAD_0001,   0,32'h0040_0100,0,0,NOP);
        vecs[16] = mk(0,0,0,1,0,0,               0,32'h0040_0100,0,0,NOP);
        vecs[17] = mk(0,0,0,1,1,32'hDEAD_0002,   0,32'h0040_0100,0,0,NOP);
        vecs[18] = mk(0,0,0,1,0,0,               1,32'h0040_0100,0,0,NOP);
        vecs[19] = mk(0,0,0,0,1,32'hCAFE_0100,   1,32'h0040_0104,0,0,NOP);
        vecs[20] = mk(0,0,0,0,0,0,               1,32'h0040_0104,1,32'h0040_0100,32'hCAFE_0100);
        vecs[21] = mk(0,1,32'hFFFF_FFFC,0,0,0,   0,32'h0040_0104,0,0,NOP);
        vecs[22] = mk(0,0,0,1,0,0,               1,32'hFFFF_FFFC,0,0,NOP);
        vecs[23] = mk(0,0,0,0,1,32'h1234_5678,   1,32'h0000_0000,0,0,NOP);
        vecs[24] = mk(0,0,0,0,0,0,               1,32'h0000_0000,1,32'hFFFF_FFFC,32'h1234_5678);
        vecs[25] = mk(0,0,0,0,1,32'hBAD0_0BAD,   1,32'h0000_0000,0,0,NOP);
        vecs[26] = mk(0,0,0,0,0,0,               1,32'h0000_0000,0,0,NOP);

        rst = 1'b1;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check32("reset imem_req", {31'b0, imem_req}, 32'h0);
        check32("reset imem_addr", imem_addr, 32'h0040_0000);
        check32("reset if_valid", {31'b0, if_valid}, 32'h0);
        check32("reset if_pc", if_pc, 32'h0);
        check32("reset if_instr", if_instr, NOP);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
            @(negedge clk);
        end

        // Restart at a fresh address with nothing in flight, then stream
        // against a memory with random grant, latency 1-5 and random stall.
        applyStimulus(mk(0,1,32'h0050_0000,0,0,0,0,0,0,0,0));
        @(negedge clk);
        expPc      = 32'h0050_0000;
        expReqAddr = 32'h0050_0000;
        buffered   = 0;
        consumed   = 0;
        cyc        = 0;
        lastDue    = 0;
        for (int c = 0; c < 460; c++) begin
            redirect    = 1'b0;
            redirect_pc = '0;
            if (c < 400) begin
                stall    = ($urandom_range(0, 3) == 0);
                imem_gnt = ($urandom_range(0, 2) != 0);
            end else begin
                stall    = 1'b0;
                imem_gnt = 1'b0;
            end
            if (mq.size() > 0 && due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0] ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            #1;
            check32("rand credits<=4", {31'b0, (mq.size() + buffered) <= 4}, 32'h1);
            check32("rand if_valid", {31'b0, if_valid}, {31'b0, buffered != 0});
            if (if_valid && !stall) begin
                check32("rand if_pc", if_pc, expPc);
                check32("rand if_instr", if_instr, expPc ^ KEY);
                expPc    = expPc + 32'd4;
                buffered = buffered - 1;
                consumed = consumed + 1;
            end
            if (imem_rvalid) begin
                tmpAddr  = mq.pop_front();
                tmpDue   = due.pop_front();
                buffered = buffered + 1;
            end
            if (imem_req && imem_gnt) begin
                check32("rand imem_addr", imem_addr, expReqAddr);
                mq.push_back(imem_addr);
                d = cyc + int'($urandom_range(1, 5));
                if (d <= lastDue) d = lastDue + 1;
                lastDue = d;
                due.push_back(d);
                expReqAddr = expReqAddr + 32'd4;
            end
            @(negedge clk);
            cyc++;
        end
        check32("rand drained queue", mq.size(), 32'd0);
        check32("rand drained buffer", buffered, 32'd0);
        check32("rand progress", {31'b0, consumed >= 60}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
